// File: rtl/delay_pkg.sv
// Shared types and constants for the SPI delay-line SRAM sequencer.
package delay_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_WAIT,
      WR_GAP,
      RD_REQ,
      RD_WAIT,
      RD_GAP
   } sched_state_t;

   localparam logic [7:0] SRAM_OP_WRITE = 8'h02;
   localparam logic [7:0] SRAM_OP_READ  = 8'h03;
   localparam int         SRAM_ADDR_W   = 24;

endpackage

// File: rtl/sram_frame_builder.sv
// Packs opcode, byte address (word pointer * 2) and data into one SRAM SPI frame.
module sram_frame_builder
   import delay_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int WADDR_W = 16,
   parameter int FRAME_W = 48
) (
   input  logic [7:0]         opcode,
   input  logic [WADDR_W-1:0] word_ptr,
   input  logic [DATA_W-1:0]  data,
   output logic [FRAME_W-1:0] frame
);

   logic [SRAM_ADDR_W-1:0] byte_addr;

   always_comb begin
      byte_addr              = '0;
      byte_addr[WADDR_W:0]   = {word_ptr, 1'b0};
      frame                  = {opcode, byte_addr, data};
   end

endmodule

// File: rtl/delay_mem_scheduler.sv
// Per-sample write-then-read sequencer for the SPI delay-line SRAM; owns the
// circular-buffer pointers and the controller cs/start handshake.
module delay_mem_scheduler
   import delay_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int WADDR_W = 16,
   parameter int FRAME_W = 48,
   parameter int CS_GAP  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_tick,
   input  logic [DATA_W-1:0]  sample_in,
   input  logic [WADDR_W-1:0] delay_len,
   output logic [DATA_W-1:0]  sample_out,
   output logic               sample_valid,
   output logic               busy,
   output logic               overrun,
   output logic               spi_cs,
   output logic [FRAME_W-1:0] spi_tx_data,
   input  logic [FRAME_W-1:0] spi_rx_data,
   input  logic               spi_done
);

   localparam int               GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   sched_state_t       state_q, state_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [WADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [WADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  out_q, out_d;
   logic               cs_q, cs_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;

   logic [7:0]         fb_op;
   logic [WADDR_W-1:0] fb_ptr;
   logic [DATA_W-1:0]  fb_data;
   logic [FRAME_W-1:0] fb_frame;
   logic               unused_rx;

   // The builder only ever serves two moments: the write frame while idle and
   // the read frame when the write completes.
   assign fb_op     = (state_q == IDLE) ? SRAM_OP_WRITE : SRAM_OP_READ;
   assign fb_ptr    = (state_q == IDLE) ? wr_ptr_q : rd_ptr_q;
   assign fb_data   = (state_q == IDLE) ? sample_in : '0;
   assign unused_rx = ^spi_rx_data[FRAME_W-1:DATA_W];

   sram_frame_builder #(
      .DATA_W  (DATA_W),
      .WADDR_W (WADDR_W),
      .FRAME_W (FRAME_W)
   ) u_frame_builder (
      .opcode   (fb_op),
      .word_ptr (fb_ptr),
      .data     (fb_data),
      .frame    (fb_frame)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gap_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tx_q      <= '0;
         out_q     <= '0;
         cs_q      <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         tx_q      <= tx_d;
         out_q     <= out_d;
         cs_q      <= cs_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE:    if (sample_tick) state_d = WR_REQ;
         WR_REQ:  if (!spi_done) state_d = WR_WAIT;
         WR_WAIT: if (spi_done) begin
            state_d   = WR_GAP;
            gap_cnt_d = '0;
         end
         WR_GAP:  if (gap_cnt_q == GAP_LAST) state_d = RD_REQ;
                  else gap_cnt_d = gap_cnt_q + GAP_W'(1);
         RD_REQ:  if (!spi_done) state_d = RD_WAIT;
         RD_WAIT: if (spi_done) begin
            state_d   = RD_GAP;
            gap_cnt_d = '0;
         end
         RD_GAP:  if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                  else gap_cnt_d = gap_cnt_q + GAP_W'(1);
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      tx_d      = tx_q;
      out_d     = out_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      overrun_d = overrun_q;
      // cs is registered from the next state so it never glitches at the pins.
      cs_d      = !(state_d inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT});
      if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
         IDLE: if (sample_tick) begin
            rd_ptr_d = wr_ptr_q - delay_len;
            tx_d     = fb_frame;
            busy_d   = 1'b1;
         end
         WR_WAIT: if (spi_done) begin
            wr_ptr_d = wr_ptr_q + WADDR_W'(1);
            tx_d     = fb_frame;
         end
         RD_WAIT: if (spi_done) begin
            out_d   = spi_rx_data[DATA_W-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b0;
         end
         default: ;
      endcase
   end

   assign sample_out   = out_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign spi_cs       = cs_q;
   assign spi_tx_data  = tx_q;

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Bench for delay_mem_scheduler: SPI controller + SRAM model, reference delay line.
module tb_delay_mem_scheduler;

   localparam int DW        = 16;
   localparam int WA        = 4;
   localparam int FW        = 48;
   localparam int GAP       = 4;
   localparam int N         = 1 << WA;
   localparam int FRAME_CYC = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sample_tick = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic [WA-1:0] delay_len = '0;
   logic [DW-1:0] sample_out;
   logic          sample_valid, busy, overrun, spi_cs;
   logic [FW-1:0] spi_tx_data;
   logic [FW-1:0] spi_rx_data = '0;
   logic          spi_done = 1'b1;

   int checks = 0;
   int passes = 0;
   int tx_viol = 0;

   logic [FW-1:0] frame_log[$];
   logic [DW-1:0] sram[N];
   logic [DW-1:0] ref_mem[N];
   int            ref_wp = 0;

   always #5 clk = ~clk;

   delay_mem_scheduler #(
      .DATA_W (DW), .WADDR_W (WA), .FRAME_W (FW), .CS_GAP (GAP)
   ) dut (
      .clk (clk), .rst (rst), .sample_tick (sample_tick), .sample_in (sample_in),
      .delay_len (delay_len), .sample_out (sample_out), .sample_valid (sample_valid),
      .busy (busy), .overrun (overrun), .spi_cs (spi_cs), .spi_tx_data (spi_tx_data),
      .spi_rx_data (spi_rx_data), .spi_done (spi_done)
   );

   // Controller + SRAM model: starts a frame on cs low, completes FRAME_CYC later.
   initial begin
      bit            cbusy = 0;
      int            cnt = 0;
      logic [FW-1:0] fr = '0;
      int            word;
      foreach (sram[i]) sram[i] = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cbusy = 0;
            spi_done = 1'b1;
         end else if (!cbusy && !spi_cs && spi_done) begin
            fr = spi_tx_data;
            frame_log.push_back(fr);
            spi_done = 1'b0;
            cbusy = 1;
            cnt = FRAME_CYC;
         end else if (cbusy) begin
            cnt--;
            if (cnt == 0) begin
               word = int'(fr[39:16]) / 2 % N;
               if (fr[47:40] == 8'h02) sram[word] = fr[15:0];
               spi_rx_data = {32'h0, sram[word]};
               spi_done = 1'b1;
               cbusy = 0;
            end
         end
      end
   end

   logic          prev_low = 1'b0;
   logic [FW-1:0] prev_tx = '0;
   always @(negedge clk) begin
      if (!rst && !spi_cs && prev_low && spi_tx_data !== prev_tx) tx_viol++;
      prev_low = !rst && !spi_cs;
      prev_tx  = spi_tx_data;
   end

   // Reference: a plain circular array of written samples.
   task automatic ref_step(input logic [DW-1:0] s, input logic [WA-1:0] d,
                           output logic [FW-1:0] wf, output logic [FW-1:0] rf,
                           output logic [DW-1:0] eo);
      int rp;
      wf = {8'h02, 24'(ref_wp * 2), s};
      rp = (ref_wp - int'(d) + N) % N;
      ref_mem[ref_wp] = s;
      eo = ref_mem[rp];
      rf = {8'h03, 24'(rp * 2), 16'h0000};
      ref_wp = (ref_wp + 1) % N;
   endtask

   task automatic do_reset(input bit clear_mem);
      @(negedge clk);
      rst = 1'b1;
      sample_tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_wp = 0;
      if (clear_mem) begin
         foreach (sram[i]) sram[i] = '0;
         foreach (ref_mem[i]) ref_mem[i] = '0;
      end
      frame_log.delete();
   endtask

   // Drives one tick and observes the full sequence; optional extra tick
   // injected during RD_WAIT or k cycles after sample_valid.
   task automatic run_tick(input logic [DW-1:0] s, input logic [WA-1:0] d,
                           input bit inj_rdwait, input int inj_after_valid,
                           output int nvalid, output logic [DW-1:0] outv, output int gap,
                           output logic busy_first, output logic busy_v, output bit ok);
      int phase = 0, lowcnt = 0, vcnt = -1, cyc = 0;
      nvalid = 0; outv = '0; gap = 0; ok = 0; busy_first = 1'b0; busy_v = 1'b1;
      frame_log.delete();
      @(negedge clk);
      sample_in = s; delay_len = d; sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      busy_first = busy;
      while (cyc < 400) begin
         if (sample_tick) sample_tick = 1'b0;
         case (phase)
            0: if (!spi_cs) phase = 1;
            1: if (spi_cs) begin phase = 2; gap = 1; end
            2: if (spi_cs) gap++; else phase = 3;
            default: begin
               lowcnt++;
               if (inj_rdwait && lowcnt == 4) sample_tick = 1'b1;
            end
         endcase
         if (sample_valid) begin
            nvalid++;
            outv = sample_out;
            if (vcnt < 0) begin vcnt = 0; busy_v = busy; end
         end
         if (vcnt >= 0) begin
            if (vcnt == inj_after_valid) sample_tick = 1'b1;
            if (vcnt == GAP + 3) begin ok = 1; break; end
            vcnt++;
         end
         @(negedge clk);
         cyc++;
      end
      sample_tick = 1'b0;
   endtask

   task automatic test_reset();
      int k;
      #1 rst = 1'b1;
      @(negedge clk);
      checks++; if (spi_cs !== 1'b1) $display("FAIL rst_cs got %b want 1", spi_cs); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
      checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", sample_valid); else passes++;
      checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passes++;
      checks++; if (sample_out !== '0) $display("FAIL rst_out got %h want 0", sample_out); else passes++;
      checks++; if (spi_tx_data !== '0) $display("FAIL rst_tx got %h want 0", spi_tx_data); else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sample_in = 16'h1234; delay_len = '0; sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      k = 0;
      while (spi_cs && k < 50) begin @(negedge clk); k++; end
      checks++; if (spi_cs !== 1'b0) $display("FAIL rst_mid_wait_cs_low got cs=%b want 0", spi_cs); else passes++;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (spi_cs !== 1'b1) $display("FAIL rst_mid_cs got %b want 1", spi_cs); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else passes++;
      checks++; if (spi_tx_data !== '0) $display("FAIL rst_mid_tx got %h want 0", spi_tx_data); else passes++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_wp = 0;
      frame_log.delete();
   endtask

   task automatic test_echo();
      int nv, gap; logic [DW-1:0] o; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      run_tick(16'hA5C3, '0, 0, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'hA5C3, '0, wf, rf, eo);
      checks++; if (ok !== 1'b1) $display("FAIL echo_timeout got %b want 1", ok); else passes++;
      checks++; if (frame_log.size() !== 2) $display("FAIL echo_nframes got %0d want 2", frame_log.size()); else passes++;
      checks++; if (frame_log[0] !== 48'h02_000000_A5C3) $display("FAIL echo_wr_frame got %h want 02000000a5c3", frame_log[0]); else passes++;
      checks++; if (frame_log[1] !== 48'h03_000000_0000) $display("FAIL echo_rd_frame got %h want 030000000000", frame_log[1]); else passes++;
      checks++; if (o !== 16'hA5C3) $display("FAIL echo_out got %h want a5c3", o); else passes++;
      checks++; if (nv !== 1) $display("FAIL echo_nvalid got %0d want 1", nv); else passes++;
      checks++; if (gap !== GAP) $display("FAIL echo_cs_gap got %0d want %0d", gap, GAP); else passes++;
      checks++; if (bf !== 1'b1) $display("FAIL echo_busy_early got %b want 1", bf); else passes++;
      checks++; if (bv !== 1'b0) $display("FAIL echo_busy_at_valid got %b want 0", bv); else passes++;
   endtask

   task automatic test_delay_sequence();
      int nv, gap; logic [DW-1:0] o; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      do_reset(1);
      for (int k = 1; k <= 10; k++) begin
         run_tick(DW'(k), WA'(4), 0, -1, nv, o, gap, bf, bv, ok);
         ref_step(DW'(k), WA'(4), wf, rf, eo);
         checks++; if (ok !== 1'b1 || nv !== 1) $display("FAIL seq_valid k=%0d got ok=%b nv=%0d want 1/1", k, ok, nv); else passes++;
         checks++; if (o !== DW'((k > 4) ? k - 4 : 0)) $display("FAIL seq_out k=%0d got %h want %h", k, o, DW'((k > 4) ? k - 4 : 0)); else passes++;
         checks++; if (frame_log.size() !== 2 || frame_log[0] !== wf || frame_log[1] !== rf)
            $display("FAIL seq_frames k=%0d got %h/%h want %h/%h", k, frame_log[0], frame_log[1], wf, rf); else passes++;
      end
   endtask

   task automatic test_wrap();
      int nv, gap; logic [DW-1:0] o; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      while (ref_wp != N - 1) begin
         run_tick(DW'(16'h0100 + ref_wp), WA'(2), 0, -1, nv, o, gap, bf, bv, ok);
         ref_step(DW'(16'h0100 + ref_wp), WA'(2), wf, rf, eo);
      end
      run_tick(16'hBEEF, WA'(1), 0, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'hBEEF, WA'(1), wf, rf, eo);
      checks++; if (frame_log[0][39:16] !== 24'((N - 1) * 2)) $display("FAIL wrap_wr_addr got %h want %h", frame_log[0][39:16], 24'((N - 1) * 2)); else passes++;
      checks++; if (frame_log[1][39:16] !== 24'((N - 2) * 2)) $display("FAIL wrap_rd_addr got %h want %h", frame_log[1][39:16], 24'((N - 2) * 2)); else passes++;
      checks++; if (o !== eo) $display("FAIL wrap_out got %h want %h", o, eo); else passes++;
      run_tick(16'h0042, WA'(3), 0, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'h0042, WA'(3), wf, rf, eo);
      checks++; if (frame_log[0][39:16] !== 24'h000000) $display("FAIL wrap_next_addr got %h want 000000", frame_log[0][39:16]); else passes++;
      checks++; if (frame_log[1] !== rf || o !== eo) $display("FAIL wrap_next_rd got %h/%h want %h/%h", frame_log[1], o, rf, eo); else passes++;
   endtask

   task automatic test_overrun();
      int nv, gap; logic [DW-1:0] o; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      checks++; if (overrun !== 1'b0) $display("FAIL ovr_before got %b want 0", overrun); else passes++;
      run_tick(16'h7777, WA'(1), 1, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'h7777, WA'(1), wf, rf, eo);
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else passes++;
      checks++; if (nv !== 1 || frame_log.size() !== 2) $display("FAIL ovr_single got nv=%0d frames=%0d want 1/2", nv, frame_log.size()); else passes++;
      checks++; if (o !== eo) $display("FAIL ovr_out got %h want %h", o, eo); else passes++;
      run_tick(16'h1111, WA'(0), 0, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'h1111, WA'(0), wf, rf, eo);
      checks++; if (frame_log[0] !== wf) $display("FAIL ovr_ptr got %h want %h", frame_log[0], wf); else passes++;
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else passes++;
   endtask

   task automatic test_gap_drop();
      int nv, gap; logic [DW-1:0] o; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      do_reset(0);
      checks++; if (overrun !== 1'b0) $display("FAIL gap_rst_overrun got %b want 0", overrun); else passes++;
      run_tick(16'h2222, WA'(0), 0, GAP - 1, nv, o, gap, bf, bv, ok);
      ref_step(16'h2222, WA'(0), wf, rf, eo);
      checks++; if (overrun !== 1'b1) $display("FAIL gap_last_cycle_overrun got %b want 1", overrun); else passes++;
      checks++; if (frame_log.size() !== 2 || ok !== 1'b1) $display("FAIL gap_no_extra_frames got %0d ok=%b want 2/1", frame_log.size(), ok); else passes++;
      run_tick(16'h3333, WA'(1), 0, -1, nv, o, gap, bf, bv, ok);
      ref_step(16'h3333, WA'(1), wf, rf, eo);
      checks++; if (frame_log[0] !== wf || o !== eo) $display("FAIL gap_next got %h/%h want %h/%h", frame_log[0], o, wf, eo); else passes++;
   endtask

   task automatic test_random();
      int nv, gap; logic [DW-1:0] o, s; logic [WA-1:0] d; logic bf, bv; bit ok;
      logic [FW-1:0] wf, rf; logic [DW-1:0] eo;
      for (int i = 0; i < 24; i++) begin
         s = DW'($urandom);
         d = WA'($urandom_range(0, N - 1));
         run_tick(s, d, 0, -1, nv, o, gap, bf, bv, ok);
         ref_step(s, d, wf, rf, eo);
         checks++; if (ok !== 1'b1 || nv !== 1 || gap !== GAP) $display("FAIL rnd_seq i=%0d got ok=%b nv=%0d gap=%0d", i, ok, nv, gap); else passes++;
         checks++; if (frame_log.size() !== 2 || frame_log[0] !== wf || frame_log[1] !== rf)
            $display("FAIL rnd_frames i=%0d got %h/%h want %h/%h", i, frame_log[0], frame_log[1], wf, rf); else passes++;
         checks++; if (o !== eo) $display("FAIL rnd_out i=%0d got %h want %h", i, o, eo); else passes++;
      end
      checks++; if (tx_viol !== 0) $display("FAIL tx_stable_under_cs got %0d changes want 0", tx_viol); else passes++;
   endtask

   initial begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      test_reset();
      test_echo();
      test_delay_sequence();
      test_wrap();
      test_overrun();
      test_gap_drop();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/delay_mem_scheduler.md
Name: delay_mem_scheduler

Overview:
- Per-sample sequencer for the SPI delay-line SRAM (23LC1024-class, 24-bit byte address, sequential mode).
- Each audio sample tick runs two SPI frames back-to-back through the shared fast SPI controller:
  - a WRITE of the incoming sample at the write pointer;
  - a READ of the delayed sample at (write pointer − delay length).
- Owns the circular-buffer pointers, builds the TX frames, drives the controller's cs/start line, and returns the delayed sample with a valid strobe.
- Sits between the codec sample interface and the SPI controller (controller TX_WIDTH = RX_WIDTH = FRAME_W).

Parameters:
- DATA_W, 16, audio sample width.
- WADDR_W, 16, word-address width; the buffer holds 2**WADDR_W samples.
- FRAME_W, 48, SPI frame width: 8 opcode + 24 byte address + DATA_W data.
- CS_GAP, 4, minimum clk cycles cs is held high between frames.

Ports:
- clk  in  1  system clock; same clock as the SPI controller.
- rst  in  1  asynchronous reset, active-high.
- sample_tick  in  1  one-cycle pulse; a new sample_in is present.
- sample_in  in  DATA_W  sample to store; captured on sample_tick.
- delay_len  in  WADDR_W  delay in samples; sampled once per tick.
- sample_out  out  DATA_W  delayed sample read back.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high from the accepted tick until sample_valid.
- overrun  out  1  sticky; a tick arrived while busy. Cleared only by rst.
- spi_cs  out  1  active-low frame request to the controller and SRAM chip select.
- spi_tx_data  out  FRAME_W  frame loaded by the controller while its done is high.
- spi_rx_data  in  FRAME_W  controller received frame, valid when spi_done is high.
- spi_done  in  1  controller idle flag (high = idle / frame complete).

Behaviour:
- Reset (async, rst=1), applied immediately, including mid-frame:
  - spi_cs=1, sample_out=0, sample_valid=0, busy=0, overrun=0;
  - wr_ptr=0, state=IDLE, spi_tx_data=0.
- States: IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, RD_GAP.
- IDLE:
  - On sample_tick, capture sample_in and delay_len.
  - Compute rd_ptr = (wr_ptr − delay_len) mod 2**WADDR_W (natural wrap).
  - Load spi_tx_data = {8'h02, byte_addr(wr_ptr), sample_in}. byte_addr = zero-extend to 24 bits of {ptr, 1'b0}.
  - Assert busy and go to WR_REQ.
- WR_REQ: spi_cs=0. Stay until spi_done=0 (controller has seen the falling edge), then go to WR_WAIT.
- WR_WAIT: spi_cs=0. On spi_done=1, set spi_cs=1, increment wr_ptr (wraps 2**WADDR_W−1 → 0), and go to WR_GAP.
- WR_GAP:
  - spi_cs=1 for exactly CS_GAP cycles.
  - On entry, load spi_tx_data = {8'h03, byte_addr(rd_ptr), DATA_W'0}.
  - Then go to RD_REQ.
- RD_REQ / RD_WAIT: same handshake as the write frame.
- On RD_WAIT exit:
  - sample_out ← spi_rx_data[DATA_W-1:0];
  - sample_valid pulses 1 cycle;
  - go to RD_GAP.
- RD_GAP:
  - CS_GAP cycles with spi_cs=1, then IDLE.
  - busy deasserts on entry to RD_GAP (the same cycle sample_valid is high); a tick during RD_GAP is overrun.
- spi_tx_data is stable for the whole frame; it changes only in IDLE-exit and WR_GAP-entry cycles, never while spi_cs=0.
- sample_tick while busy or in RD_GAP:
  - the tick is dropped and overrun is set;
  - the current sequence completes unaffected; wr_ptr is not advanced for the dropped sample.
- sample_tick coincident with the last RD_GAP cycle: dropped (overrun). It is accepted only in IDLE.
- delay_len=0: reads the word just written; sample_out = sample_in of the same tick.
- delay_len near wrap: wr_ptr=3, delay_len=5 → rd_ptr=2**WADDR_W−2.
- Latency, tick to sample_valid: 2×(controller frame time) + CS_GAP + 4 handshake cycles, ≤ one sample period by system sizing.
- No timeout: a stalled spi_done holds the block in *_WAIT. Only rst exits.

Decomposition:
- Shared package delay_pkg, containing:
  - state typedef sched_state_t;
  - opcode constants SRAM_OP_WRITE=8'h02, SRAM_OP_READ=8'h03;
  - SRAM_ADDR_W=24.
- One natural sub-module: sram_frame_builder (combinational). Inputs: opcode, word pointer, data. Output: FRAME_W frame.
- CS gap counter: a small local counter, not a sub-module.

Test Plan:
- Reset mid-WR_WAIT (rst asserted with spi_cs=0) → same cycle spi_cs=1, busy=0; wr_ptr=0; next tick writes byte address 0.
- Tick with sample_in=16'hA5C3, wr_ptr=0, delay_len=0, controller model echoing the written word → tx frames 48'h02_000000_A5C3 then 48'h03_000000_0000; sample_out=16'hA5C3 with a 1-cycle sample_valid; wr_ptr=1.
- Ten ticks with sample_in=k, delay_len=4, SRAM model attached → from the 5th tick on, sample_out=k−4; before that, reads return model reset contents (0).
- Wrap: preload wr_ptr=16'hFFFF, delay_len=1 → write byte address 24'h01FFFE, read byte address 24'h01FFFC; next write at 24'h000000.
- Tick during RD_WAIT → overrun=1 and sticky; sequence still yields exactly one sample_valid; wr_ptr advances by 1 only.
- cs gap: measure spi_cs high between write and read frames = CS_GAP cycles (4). spi_tx_data never changes while spi_cs=0 (assertion).
